fp13_minmax_seq: RTL and testbench

- Frame-based min/max finder for the team's 13-bit floating-point format:
  - bit 12: sign.
  - bits 11:8: unsigned exponent.
  - bits 7:0: normalised significand.
- One greater-than comparator is shared between the running-maximum and running-minimum updates; an FSM sequences it.
- Sits between a sample producer (valid/ready) and a result consumer (valid/ready) in the datapath.

---
 rtl/fp13_minmax_seq.sv | 178 +++++++++++++++++
 tb/tb_fp13_minmax_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp13_minmax_seq.sv
// Frame-based running min/max finder for 13-bit sign/exponent/significand samples.
// A single shared greater-than comparator is time-multiplexed between the max and min updates.
module fp13_minmax_seq #(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [12:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [12:0]      max_out,
   output logic [12:0]      min_out,
   output logic [CNT_W-1:0] max_idx,
   output logic [CNT_W-1:0] min_idx,
   output logic             busy
);

   localparam int unsigned DW = 13;
   localparam int unsigned MW = 12;
   // One extra bit so a terminal count of 2^CNT_W is representable without wrapping
   localparam int unsigned CW = CNT_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRST,
      S_WAIT_IN,
      S_CMP_MAX,
      S_CMP_MIN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [DW-1:0]    smp_q, smp_d;
   logic [CNT_W-1:0] tag_q, tag_d;
   logic [DW-1:0]    max_q, max_d, min_q, min_d;
   logic [CNT_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [DW-1:0]    cmp_a, cmp_b;
   logic             cmp_gt_c;

   // Sign-magnitude a > b; a zero magnitude is treated as non-negative so -0 equals +0
   function automatic logic fp13_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic          a_neg, b_neg;
      logic [MW-1:0] a_mag, b_mag;
      a_mag = a[MW-1:0];
      b_mag = b[MW-1:0];
      a_neg = a[DW-1] && (a_mag != '0);
      b_neg = b[DW-1] && (b_mag != '0);
      if (a_neg != b_neg) begin
         return b_neg;
      end else if (!a_neg) begin
         return a_mag > b_mag;
      end else begin
         return a_mag < b_mag;
      end
   endfunction

   // Operand steering for the shared comparator
   always_comb begin
      cmp_a = smp_q;
      cmp_b = max_q;
      if (state_q == S_CMP_MIN) begin
         cmp_a = min_q;
         cmp_b = smp_q;
      end
   end

   assign cmp_gt_c = fp13_gt(cmp_a, cmp_b);
   assign cnt_inc  = cnt_q + CW'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      smp_d     = smp_q;
      tag_d     = tag_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = S_FIRST;
            end
         end
         S_FIRST: begin
            if (in_valid) begin
               max_d     = in_data;
               min_d     = in_data;
               max_idx_d = '0;
               min_idx_d = '0;
               cnt_d     = CW'(1);
               state_d   = (FRAME_LEN == 1) ? S_DONE : S_WAIT_IN;
            end
         end
         S_WAIT_IN: begin
            if (in_valid) begin
               smp_d   = in_data;
               tag_d   = cnt_q[CNT_W-1:0];
               state_d = S_CMP_MAX;
            end
         end
         S_CMP_MAX: begin
            if (cmp_gt_c) begin
               max_d     = smp_q;
               max_idx_d = tag_q;
            end
            state_d = S_CMP_MIN;
         end
         S_CMP_MIN: begin
            if (cmp_gt_c) begin
               min_d     = smp_q;
               min_idx_d = tag_q;
            end
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CW'(FRAME_LEN)) ? S_DONE : S_WAIT_IN;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Handshake/status outputs are registered from the next state
      in_ready_d  = (state_d == S_FIRST) || (state_d == S_WAIT_IN);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         smp_q       <= '0;
         tag_q       <= '0;
         max_q       <= '0;
         min_q       <= '0;
         max_idx_q   <= '0;
         min_idx_q   <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         smp_q       <= smp_d;
         tag_q       <= tag_d;
         max_q       <= max_d;
         min_q       <= min_d;
         max_idx_q   <= max_idx_d;
         min_idx_q   <= min_idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign max_out   = max_q;
   assign min_out   = min_q;
   assign max_idx   = max_idx_q;
   assign min_idx   = min_idx_q;

endmodule

// File: tb/tb_fp13_minmax_seq.sv
// Bench for fp13_minmax_seq: three lanes (FRAME_LEN 4, 2, 1) driven from a vector table,
// with expected results queued at frame start and popped when out_valid appears.
module tb_fp13_minmax_seq;

   localparam int unsigned NL = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NL-1:0]        st, iv, ordy;
   logic [NL-1:0][12:0]  idat;
   wire  [NL-1:0]        ir, ov, bsy;
   wire  [NL-1:0][12:0]  mx, mn;
   wire  [NL-1:0][3:0]   mxi, mni;

   fp13_minmax_seq #(.FRAME_LEN(4), .CNT_W(4)) u_len4 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .max_out(mx[0]),
      .min_out(mn[0]), .max_idx(mxi[0]), .min_idx(mni[0]), .busy(bsy[0]));

   fp13_minmax_seq #(.FRAME_LEN(2), .CNT_W(4)) u_len2 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .max_out(mx[1]),
      .min_out(mn[1]), .max_idx(mxi[1]), .min_idx(mni[1]), .busy(bsy[1]));

   fp13_minmax_seq #(.FRAME_LEN(1), .CNT_W(4)) u_len1 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_data(idat[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .max_out(mx[2]),
      .min_out(mn[2]), .max_idx(mxi[2]), .min_idx(mni[2]), .busy(bsy[2]));

   typedef struct {
      logic [12:0] mx;
      logic [12:0] mn;
      logic [3:0]  mxi;
      logic [3:0]  mni;
   } exp_t;

   typedef struct {
      int                 lane;
      int                 n;
      logic [3:0][12:0]   s;
      exp_t               e;
      int                 bp;
      bit                 mid_start;
   } vec_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference ordering: map each sample onto a signed integer (-0 collapses to 0)
   function automatic int fval(input logic [12:0] x);
      int m;
      m = int'({20'd0, x[11:0]});
      return x[12] ? -m : m;
   endfunction

   function automatic exp_t model(input int n, input logic [3:0][12:0] s);
      exp_t e;
      e.mx = s[0]; e.mn = s[0]; e.mxi = '0; e.mni = '0;
      for (int i = 1; i < n; i++) begin
         if (fval(s[i]) > fval(e.mx)) begin e.mx = s[i]; e.mxi = 4'(i); end
         if (fval(e.mn) > fval(s[i])) begin e.mn = s[i]; e.mni = 4'(i); end
      end
      return e;
   endfunction

   function automatic vec_t mkv(input int lane, input int n,
                                input logic [12:0] a, input logic [12:0] b,
                                input logic [12:0] c, input logic [12:0] d,
                                input logic [12:0] emx, input int emxi,
                                input logic [12:0] emn, input int emni,
                                input int bp, input bit ms);
      vec_t v;
      v.lane = lane; v.n = n;
      v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
      v.e.mx = emx; v.e.mxi = 4'(emxi); v.e.mn = emn; v.e.mni = 4'(emni);
      v.bp = bp; v.mid_start = ms;
      return v;
   endfunction

   task automatic check_zero(input int k, input string tag);
      chk($sformatf("%s lane%0d max_out", tag, k), 32'(mx[k]), 0);
      chk($sformatf("%s lane%0d min_out", tag, k), 32'(mn[k]), 0);
      chk($sformatf("%s lane%0d max_idx", tag, k), 32'(mxi[k]), 0);
      chk($sformatf("%s lane%0d min_idx", tag, k), 32'(mni[k]), 0);
      chk($sformatf("%s lane%0d in_ready", tag, k), 32'(ir[k]), 0);
      chk($sformatf("%s lane%0d out_valid", tag, k), 32'(ov[k]), 0);
      chk($sformatf("%s lane%0d busy", tag, k), 32'(bsy[k]), 0);
   endtask

   // Runs one frame on lane k; returns early after accepting sample abort_at (if >= 0)
   task automatic drive_frame(input int k, input int n, input logic [3:0][12:0] s,
                              input int bp, input bit mid_start, input int abort_at);
      int   waits;
      exp_t e;
      @(negedge clk); st[k] = 1'b1;
      @(negedge clk); st[k] = 1'b0;
      for (int i = 0; i < n; i++) begin
         iv[k] = 1'b1;
         idat[k] = s[i];
         waits = 0;
         while (!ir[k] && waits < 20) begin @(negedge clk); waits++; end
         if (!ir[k]) begin
            chk($sformatf("lane%0d in_ready timeout s%0d", k, i), 0, 1);
            iv[k] = 1'b0;
            return;
         end
         chk($sformatf("lane%0d ready gap s%0d", k, i), 32'(waits), (i >= 2) ? 2 : 0);
         if (mid_start && i == 2) st[k] = 1'b1;
         @(negedge clk);
         st[k] = 1'b0;
         if (i == abort_at) return;
      end
      iv[k] = 1'b0;
      waits = 0;
      while (!ov[k] && waits < 20) begin @(negedge clk); waits++; end
      if (sb_q.size() == 0) begin
         chk($sformatf("lane%0d scoreboard empty", k), 1, 0);
         return;
      end
      e = sb_q.pop_front();
      if (!ov[k]) begin
         chk($sformatf("lane%0d out_valid timeout", k), 0, 1);
         return;
      end
      chk($sformatf("lane%0d latency", k), 32'(waits), (n > 1) ? 2 : 0);
      chk($sformatf("lane%0d max_out", k), 32'(mx[k]), 32'(e.mx));
      chk($sformatf("lane%0d max_idx", k), 32'(mxi[k]), 32'(e.mxi));
      chk($sformatf("lane%0d min_out", k), 32'(mn[k]), 32'(e.mn));
      chk($sformatf("lane%0d min_idx", k), 32'(mni[k]), 32'(e.mni));
      for (int b = 0; b < bp; b++) begin
         st[k] = (b == 0);
         @(negedge clk);
         st[k] = 1'b0;
         chk($sformatf("lane%0d bp%0d max_out", k, b), 32'(mx[k]), 32'(e.mx));
         chk($sformatf("lane%0d bp%0d min_out", k, b), 32'(mn[k]), 32'(e.mn));
         chk($sformatf("lane%0d bp%0d out_valid", k, b), 32'(ov[k]), 1);
         chk($sformatf("lane%0d bp%0d in_ready", k, b), 32'(ir[k]), 0);
         chk($sformatf("lane%0d bp%0d busy", k, b), 32'(bsy[k]), 1);
      end
      ordy[k] = 1'b1;
      st[k] = (bp > 0);
      @(negedge clk);
      ordy[k] = 1'b0;
      st[k] = 1'b0;
      chk($sformatf("lane%0d post-handshake out_valid", k), 32'(ov[k]), 0);
      chk($sformatf("lane%0d post-handshake busy", k), 32'(bsy[k]), 0);
      if (bp > 0) begin
         @(negedge clk);
         chk($sformatf("lane%0d start-in-done ignored busy", k), 32'(bsy[k]), 0);
         chk($sformatf("lane%0d held max_out", k), 32'(mx[k]), 32'(e.mx));
         chk($sformatf("lane%0d held min_idx", k), 32'(mni[k]), 32'(e.mni));
      end
   endtask

   vec_t             tbl[5];
   logic [3:0][12:0] rs;
   exp_t             re;

   initial begin
      tbl[0] = mkv(0, 4, 13'h0AAA, 13'h1AAA, 13'h0DD4, 13'h1E86, 13'h0DD4, 2, 13'h1E86, 3, 0, 1'b0);
      tbl[1] = mkv(0, 4, 13'h00AE, 13'h00AE, 13'h0000, 13'h1000, 13'h00AE, 0, 13'h0000, 2, 0, 1'b0);
      tbl[2] = mkv(1, 2, 13'h0AD7, 13'h0AAA, 13'h0000, 13'h0000, 13'h0AD7, 0, 13'h0AAA, 1, 5, 1'b0);
      tbl[3] = mkv(0, 4, 13'h0100, 13'h1200, 13'h0050, 13'h0300, 13'h0300, 3, 13'h1200, 1, 0, 1'b1);
      tbl[4] = mkv(2, 1, 13'h1E86, 13'h0000, 13'h0000, 13'h0000, 13'h1E86, 0, 13'h1E86, 0, 0, 1'b0);

      st = '0; iv = '0; ordy = '0; idat = '0;
      rst_n = 1'b0;
      #23;
      for (int k = 0; k < int'(NL); k++) check_zero(k, "reset");
      @(negedge clk); rst_n = 1'b1;

      // in_valid in IDLE without start must be ignored
      iv[0] = 1'b1; idat[0] = 13'h0AAA;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("idle guard in_ready c%0d", c), 32'(ir[0]), 0);
         chk($sformatf("idle guard busy c%0d", c), 32'(bsy[0]), 0);
      end
      iv[0] = 1'b0;

      for (int t = 0; t < 5; t++) begin
         sb_q.push_back(tbl[t].e);
         drive_frame(tbl[t].lane, tbl[t].n, tbl[t].s, tbl[t].bp, tbl[t].mid_start, -1);
      end

      // Reset dropped while lane 0 sits in CMP_MAX of its third sample
      rs[0] = 13'h0123; rs[1] = 13'h1456; rs[2] = 13'h0789; rs[3] = 13'h0001;
      drive_frame(0, 4, rs, 0, 1'b0, 2);
      chk("abort in CMP_MAX busy", 32'(bsy[0]), 1);
      rst_n = 1'b0;
      #1;
      check_zero(0, "mid-frame reset");
      @(negedge clk);
      iv[0] = 1'b0;
      rst_n = 1'b1;
      rs[0] = 13'h1AAA; rs[1] = 13'h1AAA; rs[2] = 13'h1AAA; rs[3] = 13'h1AAA;
      re.mx = 13'h1AAA; re.mn = 13'h1AAA; re.mxi = '0; re.mni = '0;
      sb_q.push_back(re);
      drive_frame(0, 4, rs, 0, 1'b0, -1);

      // Random frames with occasional repeats, expectations from the reference model
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 4; i++) begin
            rs[i] = 13'($urandom_range(0, 8191));
            if (i > 0 && $urandom_range(0, 3) == 0) rs[i] = rs[i-1];
         end
         re = model(4, rs);
         sb_q.push_back(re);
         drive_frame(0, 4, rs, 0, 1'b0, -1);
      end

      chk("scoreboard drained", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
